// File: rtl/bresenham_octant_walker_pkg.sv
// Shared types for the Bresenham line walker and its octant classifier.
// Widths here are the default map geometry; modules re-derive them from their own parameters.
package bresenham_pkg;

  localparam int X_W_DEF = 5;
  localparam int Y_W_DEF = 4;
  localparam int ERR_W_DEF = X_W_DEF + 3;

  typedef logic [X_W_DEF-1:0] x_coord_t;
  typedef logic [Y_W_DEF-1:0] y_coord_t;
  typedef logic signed [ERR_W_DEF-1:0] err_t;

  typedef struct packed {
    logic flip_x;
    logic flip_y;
    logic flip_identity;
  } octant_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_t;

endpackage

// File: rtl/bresenham_octant_walker_octant_classify.sv
// Combinational octant classification of a segment: returns the flip flags
// plus major/minor delta magnitudes in the normalized first-octant frame.
module octant_classify
  import bresenham_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output octant_t        oct,
  output logic [X_W-1:0] major,
  output logic [X_W-1:0] minor
);

  logic signed [X_W:0] dx;
  logic signed [Y_W:0] dy;
  logic [X_W-1:0]      ax;
  logic [Y_W-1:0]      ay;
  logic [X_W-1:0]      ay_ext;
  logic                steep;

  always_comb begin
    dx     = $signed({1'b0, x1}) - $signed({1'b0, x0});
    dy     = $signed({1'b0, y1}) - $signed({1'b0, y0});
    // Magnitudes always fit the unsigned coordinate width, so truncation is lossless.
    ax     = dx[X_W] ? X_W'(-dx) : X_W'(dx);
    ay     = dy[Y_W] ? Y_W'(-dy) : Y_W'(dy);
    ay_ext = X_W'(ay);
    steep  = (ay_ext > ax);

    major             = steep ? ay_ext : ax;
    minor             = steep ? ax : ay_ext;
    oct.flip_identity = steep;
    oct.flip_x        = steep ? dy[Y_W] : dx[X_W];
    oct.flip_y        = steep ? dx[X_W] : dy[Y_W];
  end

endmodule

// File: rtl/bresenham_octant_walker.sv
// Walks the Bresenham point sequence of one segment in the normalized
// first-octant frame, one point per out handshake, with octant flags and origin.
module bresenham_octant_walker
  import bresenham_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] in_x0,
  input  logic [X_W-1:0] in_x1,
  input  logic [Y_W-1:0] in_y0,
  input  logic [Y_W-1:0] in_y1,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output logic           out_flip_x,
  output logic           out_flip_y,
  output logic           out_flip_identity,
  output logic [X_W-1:0] out_x0,
  output logic [Y_W-1:0] out_y0,
  output logic           out_last
);

  localparam int ERR_W = X_W + 3;

  walk_state_t state_q, state_d;

  octant_t        oct_c, oct_q;
  logic [X_W-1:0] major_c, minor_c;
  logic [X_W-1:0] major_q, minor_q;
  logic [X_W-1:0] u_q;
  logic [Y_W-1:0] v_q;
  logic [X_W-1:0] x0_q;
  logic [Y_W-1:0] y0_q;

  logic signed [ERR_W-1:0] err_q;
  logic signed [ERR_W-1:0] err_init_c;
  logic signed [ERR_W-1:0] step_diag_c;
  logic signed [ERR_W-1:0] step_axial_c;

  logic accept;
  logic advance;
  logic last_pt;
  logic err_pos;

  octant_classify #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_classify (
    .x0    (in_x0),
    .x1    (in_x1),
    .y0    (in_y0),
    .y1    (in_y1),
    .oct   (oct_c),
    .major (major_c),
    .minor (minor_c)
  );

  always_comb begin
    err_init_c   = $signed({2'b00, minor_c, 1'b0}) - $signed({3'b000, major_c});
    step_axial_c = $signed({2'b00, minor_q, 1'b0});
    step_diag_c  = $signed({2'b00, minor_q, 1'b0}) - $signed({2'b00, major_q, 1'b0});
    err_pos      = !err_q[ERR_W-1] && (err_q != '0);
    last_pt      = (u_q == major_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_pt) begin
            state_d = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept stage: latch classification and origin; walk stage: step the error term.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oct_q   <= '0;
      major_q <= '0;
      minor_q <= '0;
      u_q     <= '0;
      v_q     <= '0;
      err_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
    end else if (accept) begin
      oct_q   <= oct_c;
      major_q <= major_c;
      minor_q <= minor_c;
      u_q     <= '0;
      v_q     <= '0;
      err_q   <= err_init_c;
      x0_q    <= in_x0;
      y0_q    <= in_y0;
    end else if (advance) begin
      u_q <= u_q + 1'b1;
      if (err_pos) begin
        v_q   <= v_q + 1'b1;
        err_q <= err_q + step_diag_c;
      end else begin
        err_q <= err_q + step_axial_c;
      end
    end
  end

  assign out_x             = u_q;
  assign out_y             = v_q;
  assign out_flip_x        = oct_q.flip_x;
  assign out_flip_y        = oct_q.flip_y;
  assign out_flip_identity = oct_q.flip_identity;
  assign out_x0            = x0_q;
  assign out_y0            = y0_q;
  assign out_last          = (state_q == ST_WALK) && last_pt;

endmodule

// File: tb/tb_bresenham_octant_walker.sv
// Bench for bresenham_octant_walker: directed segments, backpressure, mid-walk
// reset and random segments against a closed-form rounding model of the line.
module tb_bresenham_octant_walker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_x0, in_x1;
  logic [3:0] in_y0, in_y1;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_x;
  logic [3:0] out_y;
  logic       out_flip_x, out_flip_y, out_flip_identity;
  logic [4:0] out_x0;
  logic [3:0] out_y0;
  logic       out_last;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bresenham_octant_walker #(
    .X_W (5),
    .Y_W (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_x0             (in_x0),
    .in_x1             (in_x1),
    .in_y0             (in_y0),
    .in_y1             (in_y1),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_x             (out_x),
    .out_y             (out_y),
    .out_flip_x        (out_flip_x),
    .out_flip_y        (out_flip_y),
    .out_flip_identity (out_flip_identity),
    .out_x0            (out_x0),
    .out_y0            (out_y0),
    .out_last          (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
  endtask

  // Ideal line: v_k is k*m/M rounded to nearest with exact halves rounding down.
  function automatic int ideal_v(input int k, input int mj, input int mn);
    if (mj == 0) return 0;
    return (2 * k * mn + mj - 1) / (2 * mj);
  endfunction

  task automatic run_seg(input int x0, input int y0, input int x1, input int y1,
                         input int stall_k, input int stall_n);
    int dx, dy, ax, ay, mj, mn, vk, steep, efx, efy, a, b, mx, my;
    dx    = x1 - x0;
    dy    = y1 - y0;
    ax    = (dx < 0) ? -dx : dx;
    ay    = (dy < 0) ? -dy : dy;
    steep = (ay > ax) ? 1 : 0;
    mj    = steep ? ay : ax;
    mn    = steep ? ax : ay;
    efx   = steep ? int'(dy < 0) : int'(dx < 0);
    efy   = steep ? int'(dx < 0) : int'(dy < 0);

    wait_idle();
    in_valid = 1'b1;
    in_x0 = 5'(x0); in_x1 = 5'(x1);
    in_y0 = 4'(y0); in_y1 = 4'(y1);
    @(negedge clk);
    for (int k = 0; k <= mj; k++) begin
      vk = ideal_v(k, mj, mn);
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("in_ready_walk", {31'd0, in_ready}, 32'd0);
      chk("out_x", {27'd0, out_x}, 32'(k));
      chk("out_y", {28'd0, out_y}, 32'(vk));
      chk("out_last", {31'd0, out_last}, 32'(k == mj));
      chk("flip_x", {31'd0, out_flip_x}, 32'(efx));
      chk("flip_y", {31'd0, out_flip_y}, 32'(efy));
      chk("flip_id", {31'd0, out_flip_identity}, 32'(steep));
      chk("out_x0", {27'd0, out_x0}, 32'(x0));
      chk("out_y0", {28'd0, out_y0}, 32'(y0));
      if (k == mj) begin
        a  = out_flip_x ? -int'(out_x) : int'(out_x);
        b  = out_flip_y ? -int'(out_y) : int'(out_y);
        mx = int'(out_x0) + (out_flip_identity ? b : a);
        my = int'(out_y0) + (out_flip_identity ? a : b);
        chk("map_end_x", 32'(mx), 32'(x1));
        chk("map_end_y", 32'(my), 32'(y1));
      end
      // Garbage on the request side while walking must be ignored.
      in_valid = 1'($urandom);
      in_x0 = 5'($urandom); in_x1 = 5'($urandom);
      in_y0 = 4'($urandom); in_y1 = 4'($urandom);
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_x", {27'd0, out_x}, 32'(k));
          chk("hold_y", {28'd0, out_y}, 32'(vk));
          chk("hold_last", {31'd0, out_last}, 32'(k == mj));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("out_last_after", {31'd0, out_last}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    int rx0, ry0, rx1, ry1, sk, sn;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x0 = '0; in_x1 = '0; in_y0 = '0; in_y1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_x", {27'd0, out_x}, 32'd0);
    chk("rst_out_y", {28'd0, out_y}, 32'd0);
    chk("rst_flags", {29'd0, out_flip_x, out_flip_y, out_flip_identity}, 32'd0);
    chk("rst_origin", {23'd0, out_x0, out_y0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seg(2, 3, 7, 5, -1, 0);
    run_seg(10, 12, 8, 2, -1, 0);
    run_seg(0, 0, 31, 15, -1, 0);
    run_seg(5, 5, 5, 5, -1, 0);
    run_seg(0, 0, 4, 4, -1, 0);
    run_seg(4, 0, 0, 4, -1, 0);
    run_seg(2, 3, 7, 5, 2, 3);

    // Abandon a walk right after its second point has been taken.
    wait_idle();
    in_valid = 1'b1;
    in_x0 = 5'd2; in_x1 = 5'd7; in_y0 = 4'd3; in_y1 = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_p0_x", {27'd0, out_x}, 32'd0);
    @(negedge clk);
    chk("abort_p1_x", {27'd0, out_x}, 32'd1);
    chk("abort_p1_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_last", {31'd0, out_last}, 32'd0);
    chk("abort_out_x", {27'd0, out_x}, 32'd0);
    run_seg(0, 0, 3, 0, -1, 0);

    for (int i = 0; i < 30; i++) begin
      rx0 = int'($urandom_range(0, 31));
      rx1 = int'($urandom_range(0, 31));
      ry0 = int'($urandom_range(0, 15));
      ry1 = int'($urandom_range(0, 15));
      sk  = int'($urandom_range(0, 40));
      sn  = int'($urandom_range(1, 3));
      run_seg(rx0, ry0, rx1, ry1, sk, sn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bresenham_octant_walker.md
Name: bresenham_octant_walker

Overview:
- Accepts a line segment as absolute grid endpoints and classifies its octant (flip_x, flip_y, flip_identity).
- Walks the Bresenham point sequence in the normalized first-octant frame, one point per cycle, under valid/ready backpressure.
- Emits normalized offsets plus octant flags and origin. The downstream flip_indices stage and adder map each point back to real map cells for the occupancy-grid update.

Parameters:
- X_W, 5, width of x coordinate and normalized major-axis offset.
- Y_W, 4, width of y coordinate and normalized minor-axis offset. X_W >= Y_W is required.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  segment request valid.
- in_ready  out  1  walker can accept a segment.
- in_x0, in_x1  in  X_W  start/end x (unsigned).
- in_y0, in_y1  in  Y_W  start/end y (unsigned).
- out_valid  out  1  point valid.
- out_ready  in  1  consumer accepts point.
- out_x  out  X_W  normalized major offset u.
- out_y  out  Y_W  normalized minor offset v.
- out_flip_x, out_flip_y, out_flip_identity  out  1 each  octant flags, constant for the whole segment.
- out_x0  out  X_W  registered in_x0.
- out_y0  out  Y_W  registered in_y0.
- out_last  out  1  final point of segment.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, out_last=0.
  - All other outputs and internal registers (err, counters) are 0.
  - Reset mid-walk abandons the segment; no further points are emitted.
- States: IDLE, WALK.
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, register the classification and go to WALK.
  - WALK: in_ready=0, out_valid=1. Go to IDLE on out_valid&out_ready&out_last.
  - in_ready is deasserted during WALK, so there is one bubble cycle between segments.
- Classification (combinational on inputs, registered at accept):
  - dx=in_x1-in_x0, signed X_W+1 bits; dy=in_y1-in_y0, signed Y_W+1 bits.
  - ax=|dx|, ay=|dy|.
  - flip_identity = (ay > ax). A tie (ay == ax) gives 0.
  - Major M = identity ? ay : ax. Minor m = identity ? ax : ay.
  - flip_x = sign of the major delta (dy if identity, else dx).
  - flip_y = sign of the minor delta.
  - A zero delta is treated as non-negative (flag = 0).
- Walk arithmetic:
  - err is signed, X_W+3 bits. Init err = 2m - M, u = 0, v = 0.
  - Each out handshake advances the point:
    - if err > 0: v += 1, err += 2(m - M).
    - else: err += 2m.
    - In both cases u += 1.
  - out_last = (u == M). M+1 points are emitted in total.
  - Degenerate segment (M=0): exactly one point (0,0) with last=1 and all flags 0.
- Latency: first point is valid the cycle after in accept. Throughput is one point per cycle while out_ready=1.
- Backpressure: while out_valid & !out_ready, all out_* signals hold stable.
- Width guarantees: u never exceeds 2^X_W - 1 and v never exceeds 2^Y_W - 1, because M ≤ 31 when not steep and M ≤ 15 when steep. No wrap can occur.
- in_* values are ignored outside IDLE.

Decomposition:
- Package bresenham_pkg:
  - X_W/Y_W defaults.
  - typedefs for x_coord_t / y_coord_t.
  - packed struct octant_t {flip_x, flip_y, flip_identity}.
  - err_t signed width.
- Sub-module octant_classify: combinational; inputs are the endpoints, outputs are octant_t, M, and m. Reusable by the scan-matcher ray caster.
- The FSM, error accumulator and counters stay in bresenham_octant_walker.

Test Plan:
- (2,3)->(7,5), out_ready=1:
  - flags 0/0/0.
  - Points (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); last asserted only on (5,2).
  - in_ready returns to 1 the cycle after the final handshake.
- (10,12)->(8,2):
  - flip_identity=1, flip_x=1, flip_y=1.
  - 11 points, u 0..10, final point (10,2).
  - Chained through flip_indices plus origin, the final point lands at cell (8,2).
- (0,0)->(31,15):
  - 32 points, final (31,15), no overflow.
  - Also run (5,5)->(5,5): a single point (0,0) with last=1.
- Tie (0,0)->(4,4): flip_identity=0 and points (k,k) for k=0..4. Also run (4,0)->(0,4): flip_x=1, flip_y=0.
- Backpressure: with (2,3)->(7,5), hold out_ready=0 for 3 cycles at point (2,1). out_x, out_y and out_last stay constant throughout, and the sequence then resumes unchanged.
- Reset mid-walk: pulse rst_n=0 for 1 cycle after the 2nd point.
  - Next cycle: out_valid=0, in_ready=1.
  - A new segment (0,0)->(3,0) yields exactly (0,0),(1,0),(2,0),(3,0).
